// File: rtl/debug_data_sender.sv
// ---------------------------------------------------------------------------
// debug_data_sender
//
// Purpose:
//   Streams a snapshot of the processor's debug state to a byte-wide UART
//   transmitter while the debug control FSM holds send_flag_i high.
//   The frame is: PC, cycle count, every register-file word, then data-memory
//   words 0..DM_DEPTH-1. Each word goes out MSB byte first. The block drives
//   the register-file and data-memory debug read ports itself. It pulses
//   send_done_o once the transmitter has finished the last byte.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   send_flag_i    level request from the control FSM
//   pc_value_i     current PC, sampled when the PC word is loaded
//   cycle_count_i  executed-cycle counter, sampled when its word is loaded
//   rf_addr_o      register-file debug read address (registered)
//   rf_data_i      register-file read data, valid one cycle after rf_addr_o
//   dm_addr_o      data-memory debug read address, word index (registered)
//   dm_data_i      data-memory read data, valid one cycle after dm_addr_o
//   tx_start_o     one-cycle byte request to the UART transmitter
//   tx_data_o      byte to send, held from tx_start_o until the next send
//   tx_done_i      one-cycle pulse from the transmitter, byte finished
//   send_done_o    one-cycle pulse, whole frame finished
// ---------------------------------------------------------------------------
module debug_data_sender #(
    parameter int NBITS     = 32,
    parameter int RF_DEPTH  = 32,
    parameter int RF_ADDR_W = 5,
    parameter int DM_DEPTH  = 32,
    parameter int DM_ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 send_flag_i,
    input  logic [NBITS-1:0]     pc_value_i,
    input  logic [NBITS-1:0]     cycle_count_i,
    output logic [RF_ADDR_W-1:0] rf_addr_o,
    input  logic [NBITS-1:0]     rf_data_i,
    output logic [DM_ADDR_W-1:0] dm_addr_o,
    input  logic [NBITS-1:0]     dm_data_i,
    output logic                 tx_start_o,
    output logic [7:0]           tx_data_o,
    input  logic                 tx_done_i,
    output logic                 send_done_o
);

    localparam int BYTES = NBITS / 8;
    localparam int TOTAL = 2 + RF_DEPTH + DM_DEPTH;
    localparam int WW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [WW-1:0] W_LAST     = WW'(TOTAL - 1);
    localparam logic [WW-1:0] W_RF_FIRST = WW'(2);
    localparam logic [WW-1:0] W_DM_FIRST = WW'(2 + RF_DEPTH);
    localparam logic [BW-1:0] B_LAST     = BW'(BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_DONE,
        ST_HOLD
    } state_t;

    state_t                 state_q,    state_d;
    logic [WW-1:0]          wordIdx_q,  wordIdx_d;
    logic [BW-1:0]          byteCnt_q,  byteCnt_d;
    logic [NBITS-1:0]       shift_q,    shift_d;
    logic [RF_ADDR_W-1:0]   rfAddr_q,   rfAddr_d;
    logic [DM_ADDR_W-1:0]   dmAddr_q,   dmAddr_d;
    logic                   txStart_q,  txStart_d;
    logic [7:0]             txData_q,   txData_d;
    logic                   sendDone_q, sendDone_d;
    logic [NBITS-1:0]       selWord;

    // Word selected by the current word index. By the LOAD cycle the
    // addresses issued on entry to FETCH have produced their read data.
    always_comb begin
        selWord = dm_data_i;
        if (wordIdx_q == '0) begin
            selWord = pc_value_i;
        end else if (wordIdx_q == WW'(1)) begin
            selWord = cycle_count_i;
        end else if (wordIdx_q < W_DM_FIRST) begin
            selWord = rf_data_i;
        end
    end

    // Frame sequencing: next state, word/byte counters and shift register.
    // The final word leaves the word index parked at its last value so it
    // can never wrap; only IDLE clears it for the next frame.
    always_comb begin
        state_d   = state_q;
        wordIdx_d = wordIdx_q;
        byteCnt_d = byteCnt_q;
        shift_d   = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (send_flag_i) begin
                    wordIdx_d = '0;
                    byteCnt_d = '0;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                shift_d = selWord;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done_i) begin
                    shift_d = shift_q << 8;
                    if (byteCnt_q != B_LAST) begin
                        byteCnt_d = byteCnt_q + BW'(1);
                        state_d   = ST_SEND;
                    end else begin
                        byteCnt_d = '0;
                        if (wordIdx_q != W_LAST) begin
                            wordIdx_d = wordIdx_q + WW'(1);
                            state_d   = ST_FETCH;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!send_flag_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output next-values are decoded from the next state so every output
    // comes straight from a flop. Addresses are issued on entry to FETCH,
    // so the memories' one-cycle read latency lands exactly in LOAD; the
    // memory not addressed by the current word is parked at 0.
    always_comb begin
        rfAddr_d   = rfAddr_q;
        dmAddr_d   = dmAddr_q;
        txData_d   = txData_q;
        txStart_d  = (state_d == ST_SEND);
        sendDone_d = (state_d == ST_DONE);
        if (state_d == ST_FETCH) begin
            rfAddr_d = '0;
            dmAddr_d = '0;
            if ((wordIdx_d >= W_RF_FIRST) && (wordIdx_d < W_DM_FIRST)) begin
                rfAddr_d = RF_ADDR_W'(wordIdx_d - W_RF_FIRST);
            end else if (wordIdx_d >= W_DM_FIRST) begin
                dmAddr_d = DM_ADDR_W'(wordIdx_d - W_DM_FIRST);
            end
        end
        if (state_d == ST_SEND) begin
            txData_d = shift_d[NBITS-1 -: 8];
        end
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wordIdx_q  <= '0;
            byteCnt_q  <= '0;
            shift_q    <= '0;
            rfAddr_q   <= '0;
            dmAddr_q   <= '0;
            txStart_q  <= 1'b0;
            txData_q   <= '0;
            sendDone_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wordIdx_q  <= wordIdx_d;
            byteCnt_q  <= byteCnt_d;
            shift_q    <= shift_d;
            rfAddr_q   <= rfAddr_d;
            dmAddr_q   <= dmAddr_d;
            txStart_q  <= txStart_d;
            txData_q   <= txData_d;
            sendDone_q <= sendDone_d;
        end
    end

    assign rf_addr_o   = rfAddr_q;
    assign dm_addr_o   = dmAddr_q;
    assign tx_start_o  = txStart_q;
    assign tx_data_o   = txData_q;
    assign send_done_o = sendDone_q;

endmodule
